bcd_rollover_display: RTL and testbench

//  Downstream consumer of the 7490-style decade counter's Q[3:0] output.
//  - Extends the single decade into a 4-digit BCD count (0000-9999) by detecting each 9->0 wrap of the input digit.
//  - Drives a time-multiplexed common-anode/cathode 7-segment display showing all four digits.
//  - Sits between the counter and the board display pins.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/bcd_digit.sv | 33 +++
 rtl/bcd_rollover_display.sv | 127 ++++++++++++
 tb/tb_bcd_rollover_display.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants and the BCD-to-7-segment decoder used by display blocks.
//   BCD_MAX      : largest legal BCD digit (9)
//   SEG_BLANK    : segment pattern with every segment off
//   seg7_decode  : 4-bit code -> active-high {g,f,e,d,c,b,a}; codes 10-15 blank
package seg7_pkg;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] seg7_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit
// One decade of a cascaded BCD counter.
//   Clk   in  : clock, rising edge
//   rst   in  : asynchronous active-high reset, q -> 0
//   clr   in  : synchronous clear, q -> 0, wins over inc
//   inc   in  : advance by one at the next edge (9 wraps to 0)
//   q     out : current digit value
//   carry out : combinational, high when inc arrives while q is 9
module bcd_digit
    import seg7_pkg::*;
(
    input  logic       Clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (inc) begin
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
        end
    end

    // Combinational so a whole 9..9 chain ripples within one edge.
    assign carry = inc && (q == BCD_MAX);

endmodule

// File: rtl/bcd_rollover_display.sv
// bcd_rollover_display
// Extends an upstream decade counter digit into a 4-digit BCD count by
// spotting each 9->0 wrap of the input, and scans all four digits onto a
// multiplexed 7-segment display.
//   Clk      in  : clock, rising edge
//   rst      in  : asynchronous active-high reset
//   bcd_in   in  : upstream counter digit Q[3:0] (same clock domain)
//   clr      in  : synchronous clear of d1..d3 and ovf_o; scan unaffected
//   digits_o out : {d3,d2,d1,d0}, d0 = sampled bcd_in
//   carry_o  out : one-cycle pulse on 9999 -> 0000
//   ovf_o    out : sticky overflow, cleared by clr or rst
//   seg_o    out : {g,f,e,d,c,b,a} for the digit selected by an_o
//   an_o     out : one-hot digit enable, bit i selects digit i
module bcd_rollover_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV       = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic        Clk,
    input  logic        rst,
    input  logic [3:0]  bcd_in,
    input  logic        clr,
    output logic [15:0] digits_o,
    output logic        carry_o,
    output logic        ovf_o,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o
);

    localparam int                CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    // ---------------- input sampler and wrap detector ----------------
    logic [3:0] in_r;
    logic [3:0] prev_r;
    logic       wrap;

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            in_r   <= 4'd0;
            prev_r <= 4'd0;
        end else begin
            in_r   <= bcd_in;
            prev_r <= in_r;
        end
    end

    // Only a genuine 9->0 step counts; short-modulus resets (4->0, 1->0)
    // and invalid codes never match.
    assign wrap = (prev_r == BCD_MAX) && (in_r == 4'd0);

    // ---------------- upper-digit carry chain ----------------
    logic [3:0] digit_q [4];
    logic [3:0] carry_chain;

    assign digit_q[0]     = in_r;
    assign carry_chain[0] = wrap;

    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_digit
            bcd_digit u_digit (
                .Clk   (Clk),
                .rst   (rst),
                .clr   (clr),
                .inc   (carry_chain[gi-1]),
                .q     (digit_q[gi]),
                .carry (carry_chain[gi])
            );
        end
    endgenerate

    logic carry_reg;
    logic ovf_reg;

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (clr) begin
            // A wrap coinciding with clr is discarded along with the count.
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            carry_reg <= carry_chain[3];
            if (carry_chain[3]) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // ---------------- scan prescaler, index and output registers ----------------
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       idx;
    logic [1:0]       idx_next;
    logic [3:0]       an_reg;
    logic [6:0]       seg_reg;

    always_comb begin
        idx_next = (scan_cnt == SCAN_LAST) ? idx + 2'd1 : idx;
    end

    // an_reg and seg_reg both follow idx_next so the enable and its segment
    // pattern switch on the same edge; no ghosting of the previous digit.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            an_reg   <= 4'b0001;
            seg_reg  <= seg7_decode(4'd0);
        end else begin
            scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + CNT_W'(1);
            idx      <= idx_next;
            an_reg   <= 4'b0001 << idx_next;
            seg_reg  <= seg7_decode(digit_q[idx_next]);
        end
    end

    // ---------------- outputs ----------------
    assign digits_o = {digit_q[3], digit_q[2], digit_q[1], digit_q[0]};
    assign carry_o  = carry_reg;
    assign ovf_o    = ovf_reg;
    assign seg_o    = SEG_ACTIVE_LOW ? ~seg_reg : seg_reg;
    assign an_o     = AN_ACTIVE_LOW  ? ~an_reg  : an_reg;

endmodule

// File: tb/tb_bcd_rollover_display.sv
// tb_bcd_rollover_display
// Directed bench for bcd_rollover_display with SCAN_DIV=4 and a 10 ns clock.
// An arithmetic model (integer count 0..999 for the upper digits, edge
// counter for the scan position) is checked against the DUT on every
// falling edge; literal expectations pin the model at key points.
module tb_bcd_rollover_display;

    localparam int SCAN_DIV = 4;

    logic        Clk = 1'b0;
    logic        rst;
    logic [3:0]  bcd_in;
    logic        clr;
    logic [15:0] digits_o;
    logic        carry_o;
    logic        ovf_o;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    always #5 Clk = ~Clk;

    bcd_rollover_display #(
        .SCAN_DIV       (SCAN_DIV),
        .SEG_ACTIVE_LOW (1'b0),
        .AN_ACTIVE_LOW  (1'b0)
    ) dut (
        .Clk      (Clk),
        .rst      (rst),
        .bcd_in   (bcd_in),
        .clr      (clr),
        .digits_o (digits_o),
        .carry_o  (carry_o),
        .ovf_o    (ovf_o),
        .seg_o    (seg_o),
        .an_o     (an_o)
    );

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0:       return 7'b0111111;
            1:       return 7'b0000110;
            2:       return 7'b1011011;
            3:       return 7'b1001111;
            4:       return 7'b1100110;
            5:       return 7'b1101101;
            6:       return 7'b1111101;
            7:       return 7'b0000111;
            8:       return 7'b1111111;
            9:       return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int digit_at(input int k, input int upper, input int d0);
        if (k == 0) return d0;
        if (k == 1) return upper % 10;
        if (k == 2) return (upper / 10) % 10;
        return (upper / 100) % 10;
    endfunction

    int         m_in    = 0;   // last sampled input (d0)
    int         m_prev  = 0;   // input sampled one edge earlier
    int         m_upper = 0;   // value of d3d2d1 as an integer
    int         m_n     = 0;   // edges since reset release
    logic       m_carry = 1'b0;
    logic       m_ovf   = 1'b0;
    logic [3:0] exp_an  = 4'b0001;
    logic [6:0] exp_seg = 7'b0111111;

    always @(posedge Clk or posedge rst) begin
        if (rst) begin
            m_in    <= 0;
            m_prev  <= 0;
            m_upper <= 0;
            m_n     <= 0;
            m_carry <= 1'b0;
            m_ovf   <= 1'b0;
            exp_an  <= 4'b0001;
            exp_seg <= 7'b0111111;
        end else begin
            m_in    <= int'(bcd_in);
            m_prev  <= m_in;
            m_n     <= m_n + 1;
            exp_an  <= 4'b0001 << (((m_n + 1) / SCAN_DIV) % 4);
            exp_seg <= seg_of(digit_at(((m_n + 1) / SCAN_DIV) % 4, m_upper, m_in));
            if (clr) begin
                m_upper <= 0;
                m_carry <= 1'b0;
                m_ovf   <= 1'b0;
            end else if (m_prev == 9 && m_in == 0) begin
                if (m_upper == 999) begin
                    m_upper <= 0;
                    m_carry <= 1'b1;
                    m_ovf   <= 1'b1;
                end else begin
                    m_upper <= m_upper + 1;
                    m_carry <= 1'b0;
                end
            end else begin
                m_carry <= 1'b0;
            end
        end
    end

    function automatic logic [15:0] exp_digits(input int upper, input int d0);
        return {4'((upper / 100) % 10), 4'((upper / 10) % 10), 4'(upper % 10), 4'(d0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        if (checking) begin
            check("model_digits", 32'(digits_o), 32'(exp_digits(m_upper, m_in)));
            check("model_carry",  32'(carry_o),  32'(m_carry));
            check("model_ovf",    32'(ovf_o),    32'(m_ovf));
            check("model_an",     32'(an_o),     32'(exp_an));
            check("model_seg",    32'(seg_o),    32'(exp_seg));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int v, input logic c);
        @(negedge Clk);
        bcd_in = 4'(v);
        clr    = c;
    endtask

    task automatic decades(input int n);
        for (int d = 0; d < n; d++) begin
            for (int v = 0; v < 10; v++) step(v, 1'b0);
        end
    endtask

    task automatic fast_wraps(input int n);
        for (int i = 0; i < n; i++) begin
            step(9, 1'b0);
            step(0, 1'b0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] prev_an;
        bit         found;

        rst    = 1'b1;
        clr    = 1'b0;
        bcd_in = 4'd0;
        repeat (3) @(negedge Clk);
        rst      = 1'b0;
        checking = 1'b1;

        // 1: async reset mid-count with d=0357
        decades(35);
        for (int v = 0; v <= 7; v++) step(v, 1'b0);
        @(negedge Clk);
        check("pre_reset_digits", 32'(digits_o), 32'h0357);
        #2 rst = 1'b1;
        #1;
        check("rst_digits", 32'(digits_o), 32'h0000);
        check("rst_an",     32'(an_o),     32'h1);
        check("rst_seg",    32'(seg_o),    32'(7'b0111111));
        check("rst_ovf",    32'(ovf_o),    32'h0);
        repeat (3) @(negedge Clk);
        check("rst_hold_digits", 32'(digits_o), 32'h0000);
        check("rst_hold_an",     32'(an_o),     32'h1);
        rst = 1'b0;

        // 2: 25 decades, upper digits land 2 edges after the final 0
        decades(25);
        step(0, 1'b0);
        @(negedge Clk);
        check("wrap_lat_1edge", 32'(digits_o), 32'h0240);
        @(negedge Clk);
        check("wrap_lat_2edge", 32'(digits_o), 32'h0250);

        // 3: clear, preload to 9999, then one more wrap
        step(0, 1'b1);
        step(0, 1'b0);
        fast_wraps(999);
        step(9, 1'b0);
        @(negedge Clk);
        check("preload_digits", 32'(digits_o), 32'h9999);
        check("preload_ovf",    32'(ovf_o),    32'h0);
        step(0, 1'b0);
        @(negedge Clk);
        check("roll_pending", 32'(digits_o), 32'h9990);
        @(negedge Clk);
        check("roll_digits", 32'(digits_o), 32'h0000);
        check("roll_carry",  32'(carry_o),  32'h1);
        check("roll_ovf",    32'(ovf_o),    32'h1);
        @(negedge Clk);
        check("roll_carry_end", 32'(carry_o), 32'h0);
        check("roll_ovf_stick", 32'(ovf_o),   32'h1);

        // 4: clr on the edge a wrap would take effect, d=0129
        fast_wraps(12);
        step(9, 1'b0);
        step(9, 1'b0);
        @(negedge Clk);
        check("pre_clr_digits", 32'(digits_o), 32'h0129);
        check("pre_clr_ovf",    32'(ovf_o),    32'h1);
        step(0, 1'b0);
        step(0, 1'b1);
        @(negedge Clk);
        clr = 1'b0;
        check("clr_digits", 32'(digits_o), 32'h0000);
        check("clr_ovf",    32'(ovf_o),    32'h0);
        @(negedge Clk);
        check("clr_no_late_inc", 32'(digits_o), 32'h0000);

        // 5: mod-5 and mod-2 sequences never wrap
        for (int i = 0; i < 100; i++) step(i % 5, 1'b0);
        for (int i = 0; i < 100; i++) step(i % 2, 1'b0);
        @(negedge Clk);
        check("short_mod_upper", 32'(digits_o[15:4]), 32'h000);

        // 6: scan of 4321
        step(0, 1'b1);
        step(0, 1'b0);
        fast_wraps(432);
        step(1, 1'b0);
        @(negedge Clk);
        check("scan_digits", 32'(digits_o), 32'h4321);
        found   = 1'b0;
        prev_an = an_o;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge Clk);
            if (an_o == 4'b0001 && prev_an == 4'b1000) found = 1'b1;
            else prev_an = an_o;
        end
        check("scan_sync", 32'(found), 32'h1);
        for (int i = 0; i < 16; i++) begin
            check("scan_an",  32'(an_o),  32'(4'b0001 << (i / 4)));
            check("scan_seg", 32'(seg_o), 32'(seg_of(i / 4 + 1)));
            @(negedge Clk);
        end

        // invalid code 12 on d0 shows blank
        step(12, 1'b0);
        @(negedge Clk);
        @(negedge Clk);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (an_o == 4'b0001) found = 1'b1;
            else @(negedge Clk);
        end
        check("blank_sync",   32'(found),         32'h1);
        check("blank_seg",    32'(seg_o),         32'h00);
        check("blank_digit0", 32'(digits_o[3:0]), 32'hC);

        step(0, 1'b0);
        repeat (4) @(negedge Clk);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
